// File: rtl/mod_enc_mixcol_engine.sv
`default_nettype none
// ============================================================================
// Module      : mod_enc_mixcol_engine
// Description : AES MixColumns / InvMixColumns / bypass engine. Accepts a
//               128-bit state over valid/ready, transforms COLS_PER_CYCLE
//               columns per clock and returns the block over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_enc_mixcol_engine #(
    parameter int COLS_PER_CYCLE = 4,
    parameter int OUT_REG        = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] c_cpc    = 3'(COLS_PER_CYCLE);
    // A whole block fits in one transform: done straight from the accept edge
    localparam bit         c_single = (COLS_PER_CYCLE == 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [2:0]     r_cnt;
    logic [127:0]   r_work;
    logic [1:0]     r_mode;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_live;     // holds in_ready low until the first edge after reset

    logic [127:0]   w_in_xf;     // all four columns of in_data transformed
    logic [127:0]   w_work_next; // working register with the current group transformed
    logic [3:0]     w_sel;
    logic           w_accept;
    logic           w_last;

    // GF(2^8) multiply-by-two, polynomial 0x11B
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // One column through the forward or inverse matrix; mode[1] copies through
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [1:0] mode);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (mode[1]) begin
            res = col;
        end else if (mode[0]) begin
            res = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end else begin
            res = {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                   a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                   a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                   x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
        end
        return res;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_in_xf[127-32*c -: 32]     = mix_col(in_data[127-32*c -: 32], in_mode);
        assign w_sel[c]                    = (3'(c) >= r_cnt) && (3'(c) < (r_cnt + c_cpc));
        assign w_work_next[127-32*c -: 32] = w_sel[c] ? mix_col(r_work[127-32*c -: 32], r_mode)
                                                      : r_work[127-32*c -: 32];
    end

    assign in_ready  = r_live && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign w_last    = ((r_cnt + c_cpc) == 3'd4);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    // Control FSM with working/mode registers and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_work      <= '0;
            r_mode      <= 2'b00;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_BUSY: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + c_cpc;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    // IDLE, or DONE where a drain may coincide with a new accept
                    if (w_accept) begin
                        r_mode <= in_mode;
                        r_cnt  <= 3'd0;
                        if (c_single) begin
                            r_work      <= w_in_xf;
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_work      <= in_data;
                            r_state     <= S_BUSY;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic         w_enter_done;
        logic [127:0] w_done_value;
        logic [127:0] r_out;

        assign w_enter_done = (w_accept && c_single) || ((r_state == S_BUSY) && w_last);
        assign w_done_value = (r_state == S_BUSY) ? w_work_next : w_in_xf;

        // Snapshot of the finished block, loaded on entry to DONE
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_out <= '0;
            end else if (w_enter_done) begin
                r_out <= w_done_value;
            end
        end

        assign out_data = r_out;
    end else begin : g_work_out
        assign out_data = r_work;
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_enc_mixcol_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_enc_mixcol_engine
// Description : Self-checking bench for mod_enc_mixcol_engine, three
//               instances (4, 1 and 2 columns per cycle) with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_enc_mixcol_engine;

    localparam logic [127:0] c_v1_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] c_v1_out = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] c_bp     = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_data_a   [3];
    logic [1:0]   in_mode_a   [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_data_a  [3];
    logic         busy_a      [3];

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_q [$];

    typedef struct {
        logic [1:0]   mode;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    mod_enc_mixcol_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_data(in_data_a[0]), .in_mode(in_mode_a[0]), .out_valid(out_valid_a[0]),
        .out_ready(out_ready_a[0]), .out_data(out_data_a[0]), .busy(busy_a[0]));

    mod_enc_mixcol_engine #(.COLS_PER_CYCLE(1), .OUT_REG(0)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_data(in_data_a[1]), .in_mode(in_mode_a[1]), .out_valid(out_valid_a[1]),
        .out_ready(out_ready_a[1]), .out_data(out_data_a[1]), .busy(busy_a[1]));

    mod_enc_mixcol_engine #(.COLS_PER_CYCLE(2), .OUT_REG(1)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .in_data(in_data_a[2]), .in_mode(in_mode_a[2]), .out_valid(out_valid_a[2]),
        .out_ready(out_ready_a[2]), .out_data(out_data_a[2]), .busy(busy_a[2]));

    // Generic shift-and-add GF(2^8) multiply, polynomial 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix coefficient at offset d = (col - row) mod 4
    function automatic logic [7:0] coef(input logic inv, input int d);
        case (d)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [1:0] mode, input logic [127:0] din);
        logic [127:0] res;
        logic [7:0]   acc;
        if (mode[1]) return din;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef(mode[0], (j - r + 4) % 4), din[127-8*(4*c+j) -: 8]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int exp_lat(input int k);
        case (k)
            0:       return 0;   // single transform at the accept edge
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every handed-off block against the queue head
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset && out_valid_a[k] && out_ready_a[k]) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output inst%0d: got %h expected no output", k, out_data_a[k]);
                end else begin
                    check($sformatf("data_inst%0d", k), out_data_a[k], exp_q.pop_front());
                end
            end
        end
    end

    // Send one block, scramble inputs after accept, measure latency and busy cycles
    task automatic run_lat(input int k, input logic [1:0] mode, input logic [127:0] din,
                           input logic [127:0] dout, input string name);
        int lat;
        int nbusy;
        bit got;
        @(posedge clk); #1;
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = din;
        in_mode_a[k]  = mode;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (in_ready_a[k]) begin
                exp_q.push_back(dout);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid_a[k] = 1'b0;
        in_data_a[k]  = ~din;
        in_mode_a[k]  = ~mode;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: got no in_ready expected in_ready within 20 cycles", name);
            return;
        end
        lat   = 0;
        nbusy = 0;
        got   = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (out_valid_a[k]) begin
                got = 1'b1;
            end else begin
                if (busy_a[k]) nbusy++;
                @(posedge clk);
                lat++;
            end
        end
        check({name, "_lat"}, 128'(lat), 128'(exp_lat(k)));
        check({name, "_busy"}, 128'(nbusy), 128'(exp_lat(k)));
        check({name, "_busy_done"}, 128'(busy_a[k]), 128'(0));
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = '0;
            in_mode_a[k]   = 2'b00;
            out_ready_a[k] = 1'b1;
        end

        tbl[0].mode = 2'b00; tbl[0].din = c_v1_in;  tbl[0].dout = c_v1_out;
        tbl[1].mode = 2'b01; tbl[1].din = c_v1_out; tbl[1].dout = c_v1_in;
        tbl[2].mode = 2'b10; tbl[2].din = c_bp;     tbl[2].dout = c_bp;
        tbl[3].mode = 2'b11;
        tbl[3].din  = {$urandom, $urandom, $urandom, $urandom};
        tbl[3].dout = tbl[3].din;
        tbl[4].mode = 2'b00;
        tbl[4].din  = {$urandom, $urandom, $urandom, $urandom};
        tbl[4].dout = model(2'b00, tbl[4].din);
        tbl[5].mode = 2'b01;
        tbl[5].din  = {$urandom, $urandom, $urandom, $urandom};
        tbl[5].dout = model(2'b01, tbl[5].din);

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_in_ready%0d", k),  128'(in_ready_a[k]),  128'(0));
            check($sformatf("rst_out_valid%0d", k), 128'(out_valid_a[k]), 128'(0));
            check($sformatf("rst_busy%0d", k),      128'(busy_a[k]),      128'(0));
            check($sformatf("rst_out_data%0d", k),  out_data_a[k],        128'(0));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("post_rst_in_ready%0d", k), 128'(in_ready_a[k]), 128'(1));

        // Table vectors through every instance
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 6; i++)
                run_lat(k, tbl[i].mode, tbl[i].din, tbl[i].dout, $sformatf("tbl_i%0d_v%0d", k, i));

        // Backpressure on the single-cycle instance, then drain + accept on one edge
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        in_data_a[0]   = c_v1_in;
        in_mode_a[0]   = 2'b00;
        @(negedge clk);
        check("bp_accept_ready", 128'(in_ready_a[0]), 128'(1));
        exp_q.push_back(c_v1_out);
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid_a[0]), 128'(1));
            check("bp_out_data",  out_data_a[0],        c_v1_out);
            check("bp_in_ready",  128'(in_ready_a[0]),  128'(0));
            @(posedge clk); #1;
        end
        in_valid_a[0]  = 1'b1;
        in_data_a[0]   = c_v1_out;
        in_mode_a[0]   = 2'b01;
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        check("drain_accept_ready", 128'(in_ready_a[0]), 128'(1));
        exp_q.push_back(c_v1_in);
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        check("drain_accept_valid", 128'(out_valid_a[0]), 128'(1));
        check("drain_accept_data",  out_data_a[0],        c_v1_in);
        @(posedge clk); #1;

        // Reset while the two-column instance is mid-block
        in_valid_a[2] = 1'b1;
        in_data_a[2]  = c_v1_in;
        in_mode_a[2]  = 2'b00;
        @(negedge clk);
        check("mid_accept_ready", 128'(in_ready_a[2]), 128'(1));
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        @(negedge clk);
        check("mid_busy", 128'(busy_a[2]), 128'(1));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid_a[2]), 128'(0));
        check("mid_rst_out_data",  out_data_a[2],        128'(0));
        check("mid_rst_in_ready",  128'(in_ready_a[2]),  128'(0));
        check("mid_rst_busy",      128'(busy_a[2]),      128'(0));
        @(posedge clk); #1;
        check("mid_rst_hold_valid", 128'(out_valid_a[2]), 128'(0));
        check("mid_rst_hold_ready", 128'(in_ready_a[2]),  128'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_ready_before_edge", 128'(in_ready_a[2]), 128'(0));
        @(posedge clk); #1;
        check("mid_rel_ready", 128'(in_ready_a[2]), 128'(1));
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("mid_no_partial", 128'(out_valid_a[2]), 128'(0));
        end
        run_lat(2, 2'b00, c_v1_in, c_v1_out, "post_rst_v1");

        // Every pushed expectation must have been consumed
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
